data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian data memory with sized, sign/zero-extended
// loads pipelined over RD_LAT cycles. Define DMEM_ALIGN_CHECK_EN to also reject misaligned halfword/word accesses.
module data_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]           mem [DEPTH];
  logic [2:0]           nbytes;
  logic [31:0]          end_addr;
  logic                 misalign;
  logic                 bad;
  logic                 ld_ok;
  logic                 ld_bad;
  logic                 st_ok;
  logic                 st_bad;
  logic [IDX_W-1:0]     idx [4];
  logic [7:0]           rbyte [4];
  logic [31:0]          ld_word;
  logic [31:0]          ld_in;

  logic [RD_LAT-1:0]    pv;
  logic [RD_LAT-1:0]    pe;
  logic [RD_LAT*32-1:0] pd;
  logic [RD_LAT-1:0]    pv_nxt;
  logic [RD_LAT-1:0]    pe_nxt;
  logic [RD_LAT*32-1:0] pd_nxt;
  logic                 st_err;
  logic [31:0]          rd_hold;
  logic                 last_act;
  logic [31:0]          last_data;

  always_comb begin
    nbytes = 3'd4;
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign end_addr = 32'(addr) + 32'(nbytes);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad    = (size == 2'b11) || (end_addr > 32'(DEPTH)) || misalign;
  assign ld_ok  = req && !we && !bad;
  assign ld_bad = req && !we && bad;
  assign st_ok  = req && we && !bad;
  assign st_bad = req && we && bad;

  // lane g addresses byte addr+g; wrapped lanes are only used when the access is rejected
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign idx[g]   = IDX_W'(addr + ADDR_W'(g));
    assign rbyte[g] = mem[idx[g]];
  end

  always_comb begin
    ld_word = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    case (size)
      2'b00:   ld_word = {{24{sign_ext & rbyte[0][7]}}, rbyte[0]};
      2'b01:   ld_word = {{16{sign_ext & rbyte[1][7]}}, rbyte[1], rbyte[0]};
      default: ld_word = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
    endcase
  end

  assign ld_in = ld_ok ? ld_word : 32'h0;

  // memory has no reset: contents survive rst_n
  always_ff @(posedge clk) begin
    if (st_ok) begin
      mem[idx[0]] <= wdata[7:0];
      if (nbytes > 3'd1) mem[idx[1]] <= wdata[15:8];
      if (nbytes > 3'd2) begin
        mem[idx[2]] <= wdata[23:16];
        mem[idx[3]] <= wdata[31:24];
      end
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign pv_nxt = ld_ok;
    assign pe_nxt = ld_bad;
    assign pd_nxt = ld_in;
  end else begin : g_latn
    assign pv_nxt = {pv[RD_LAT-2:0], ld_ok};
    assign pe_nxt = {pe[RD_LAT-2:0], ld_bad};
    assign pd_nxt = {pd[(RD_LAT-1)*32-1:0], ld_in};
  end

  assign last_act  = pv[RD_LAT-1] | pe[RD_LAT-1];
  assign last_data = pd[RD_LAT*32-1 -: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv      <= '0;
      pe      <= '0;
      pd      <= '0;
      st_err  <= 1'b0;
      rd_hold <= '0;
    end else begin
      pv     <= pv_nxt;
      pe     <= pe_nxt;
      pd     <= pd_nxt;
      st_err <= st_bad;
      if (last_act) rd_hold <= last_data;
    end
  end

  // a rejected load carries zero data, so it drives rdata to 0 for its slot
  assign rvalid = pv[RD_LAT-1];
  assign err    = pe[RD_LAT-1] | st_err;
  assign rdata  = last_act ? last_data : rd_hold;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (RD_LAT 1..3) share stimulus; a per-cycle
// scoreboard checks rvalid, err and rdata of each against queued expectations.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata_d [3];
  logic        rvalid_d [3];
  logic        err_d [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .RD_LAT(g + 1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata_d[g]),
      .rvalid   (rvalid_d[g]),
      .err      (err_d[g])
    );
  end

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    int          due;
    int          dut;
    bit          ld;
    bit          ok;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          rq;
    bit          w;
    logic [1:0]  sz;
    bit          sx;
    logic [7:0]  a;
    logic [31:0] wd;
    bit          xerr;
    logic [31:0] xd;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic [7:0]  mref [256];
  logic [31:0] exp_rd [3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic cmp(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic check();
    for (int i = 0; i < 3; i++) begin
      bit ev;
      bit ee;
      ev = 1'b0;
      ee = 1'b0;
      foreach (sbq[j]) begin
        if (sbq[j].due == cyc && sbq[j].dut == i) begin
          if (sbq[j].ld && sbq[j].ok) begin
            ev = 1'b1;
            exp_rd[i] = sbq[j].data;
          end else begin
            ee = 1'b1;
            if (sbq[j].ld) exp_rd[i] = 32'h0;
          end
        end
      end
      cmp("rvalid", i, 32'(rvalid_d[i]), 32'(ev));
      cmp("err", i, 32'(err_d[i]), 32'(ee));
      cmp("rdata", i, rdata_d[i], exp_rd[i]);
    end
    for (int j = sbq.size() - 1; j >= 0; j--)
      if (sbq[j].due <= cyc) sbq.delete(j);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check();
  endtask

  function automatic logic [31:0] mload(logic [1:0] sz, bit sx, logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mref[a];
    b1 = mref[8'(a + 8'd1)];
    b2 = mref[8'(a + 8'd2)];
    b3 = mref[8'(a + 8'd3)];
    case (sz)
      2'b00:   return {{24{sx & b0[7]}}, b0};
      2'b01:   return {{16{sx & b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  // drive one cycle of stimulus and queue what each instance must produce
  task automatic issue(bit rq, bit w, logic [1:0] sz, bit sx, logic [7:0] a,
                       logic [31:0] wd, bit xerr, logic [31:0] xd);
    int n;
    req = rq; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    if (rq) begin
      if (w) begin
        if (xerr) begin
          for (int i = 0; i < 3; i++)
            sbq.push_back('{due: cyc + 1, dut: i, ld: 1'b0, ok: 1'b0, data: 32'h0});
        end else begin
          n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
          for (int k = 0; k < n; k++) mref[8'(a + 8'(k))] = wd[8*k +: 8];
        end
      end else begin
        for (int i = 0; i < 3; i++)
          sbq.push_back('{due: cyc + 1 + i, dut: i, ld: 1'b1, ok: !xerr,
                          data: xerr ? 32'h0 : xd});
      end
    end
    step();
    req = 1'b0; we = 1'b0; wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0;

    //            rq we size  sx addr   wdata         xerr xdata
    tbl.push_back('{1, 1, 2'b10, 0, 8'h10, 32'h11223344, 0,   32'h0});
    tbl.push_back('{1, 0, 2'b10, 0, 8'h10, 32'h0,        0,   32'h11223344});
    tbl.push_back('{1, 1, 2'b00, 0, 8'h11, 32'hDEADBEAA, 0,   32'h0});
    tbl.push_back('{1, 0, 2'b00, 1, 8'h11, 32'h0,        0,   32'hFFFFFFAA});
    tbl.push_back('{1, 0, 2'b00, 0, 8'h11, 32'h0,        0,   32'h000000AA});
    tbl.push_back('{1, 0, 2'b10, 0, 8'h10, 32'h0,        0,   32'h1122AA44});
    tbl.push_back('{1, 0, 2'b01, 0, 8'h11, 32'h0,        ALN, ALN ? 32'h0 : 32'h000022AA});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h10, 32'hFFFFFFFF, 0,   32'h0});
    tbl.push_back('{1, 0, 2'b10, 1, 8'h10, 32'h0,        0,   32'h1122AA44});
    tbl.push_back('{1, 1, 2'b01, 0, 8'hFE, 32'h5555BEEF, 0,   32'h0});
    tbl.push_back('{1, 1, 2'b10, 0, 8'hFE, 32'h01020304, 1,   32'h0});
    tbl.push_back('{1, 0, 2'b01, 0, 8'hFE, 32'h0,        0,   32'h0000BEEF});
    tbl.push_back('{1, 0, 2'b01, 1, 8'hFE, 32'h0,        0,   32'hFFFFBEEF});
    tbl.push_back('{1, 0, 2'b11, 0, 8'h10, 32'h0,        1,   32'h0});
    tbl.push_back('{1, 0, 2'b00, 0, 8'hFF, 32'h0,        0,   32'h000000BE});
    tbl.push_back('{1, 0, 2'b10, 0, 8'hFD, 32'h0,        1,   32'h0});
    tbl.push_back('{1, 1, 2'b10, 0, 8'h20, 32'hCAFEF00D, 0,   32'h0});
    tbl.push_back('{1, 1, 2'b01, 0, 8'h22, 32'hAB001234, 0,   32'h0});
    tbl.push_back('{1, 0, 2'b10, 0, 8'h20, 32'h0,        0,   32'h1234F00D});
    tbl.push_back('{1, 0, 2'b01, 1, 8'h20, 32'h0,        0,   32'hFFFFF00D});
    tbl.push_back('{1, 0, 2'b00, 1, 8'h21, 32'h0,        0,   32'hFFFFFFF0});
    tbl.push_back('{1, 0, 2'b00, 1, 8'h23, 32'h0,        0,   32'h00000012});
    tbl.push_back('{1, 1, 2'b11, 0, 8'h30, 32'h77777777, 1,   32'h0});
    tbl.push_back('{1, 0, 2'b10, 0, 8'h10, 32'h0,        0,   32'h1122AA44});

    // reset state
    step();
    step();
    rst_n = 1'b1;

    foreach (tbl[t])
      issue(tbl[t].rq, tbl[t].w, tbl[t].sz, tbl[t].sx, tbl[t].a, tbl[t].wd,
            tbl[t].xerr, tbl[t].xd);
    for (int k = 0; k < 4; k++) step();

    // back-to-back loads, plus a load right behind a store to the same word
    issue(1, 1, 2'b10, 0, 8'h14, 32'hA0A1A2A3, 0, 32'h0);
    issue(1, 1, 2'b10, 0, 8'h18, 32'hB0B1B2B3, 0, 32'h0);
    issue(1, 0, 2'b10, 0, 8'h10, 32'h0, 0, mload(2'b10, 0, 8'h10));
    issue(1, 0, 2'b10, 0, 8'h14, 32'h0, 0, mload(2'b10, 0, 8'h14));
    issue(1, 0, 2'b10, 0, 8'h18, 32'h0, 0, mload(2'b10, 0, 8'h18));
    issue(1, 1, 2'b10, 0, 8'h40, 32'h5A5A5A5A, 0, 32'h0);
    issue(1, 0, 2'b10, 0, 8'h40, 32'h0, 0, mload(2'b10, 0, 8'h40));
    issue(1, 0, 2'b00, 1, 8'h1B, 32'h0, 0, mload(2'b00, 1, 8'h1B));
    for (int k = 0; k < 4; k++) step();

    // reset lands while a load is in flight in every instance
    issue(1, 0, 2'b10, 0, 8'h14, 32'h0, 0, mload(2'b10, 0, 8'h14));
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cmp("rst_rvalid", i, 32'(rvalid_d[i]), 32'h0);
      cmp("rst_err", i, 32'(err_d[i]), 32'h0);
      cmp("rst_rdata", i, rdata_d[i], 32'h0);
    end
    sbq.delete();
    for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0;
    step();
    rst_n = 1'b1;
    issue(1, 0, 2'b10, 0, 8'h18, 32'h0, 0, mload(2'b10, 0, 8'h18));
    for (int k = 0; k < 5; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
